// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared defaults and helpers for the serial pattern detectors
package seq_detect_pkg;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 4'b1001;
    localparam int DEF_CNT_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: pattern/stream/counter bus of the serial pattern detector
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap_en;
    logic             x_valid;
    logic             x;
    logic             cnt_clr;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0] pat_q;

    modport master (
        output pat_load, pat_in, overlap_en, x_valid, x, cnt_clr,
        input  y, match_cnt, pat_q
    );

    modport slave (
        input  pat_load, pat_in, overlap_en, x_valid, x, cnt_clr,
        output y, match_cnt, pat_q
    );
endinterface

// File: rtl/seq_detect_param_cnt.sv
// seq_detect_param_cnt: saturating event counter; clear still counts a coincident event
module seq_detect_param_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= CNT_W'(inc);
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loadable PAT_W-bit serial pattern detector with
// selectable overlap, registered match pulse and saturating match count
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT),
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    seq_detect_param_if.slave bus
);
    localparam int FW = clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist, nh;
    logic [FW-1:0]    fill, nf;
    logic             hit;

    // fill gates the compare so stale history never matches after a restart
    always_comb begin
        nh  = {hist[PAT_W-2:0], bus.x};
        nf  = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
        hit = bus.x_valid && !bus.pat_load && (nf == FW'(PAT_W)) && (nh == bus.pat_q);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.pat_q <= PAT_RST;
            hist      <= '0;
            fill      <= '0;
            bus.y     <= 1'b0;
        end else begin
            if (bus.pat_load) begin
                bus.pat_q <= bus.pat_in;
                fill      <= '0;
            end else if (bus.x_valid) begin
                hist <= nh;
                fill <= (hit && !bus.overlap_en) ? '0 : nf;
            end
            bus.y <= hit;
        end

    seq_detect_param_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (bus.cnt_clr),
        .cnt (bus.match_cnt)
    );
endmodule
